alu_seq: RTL and testbench

- Multi-cycle sequencer that drives the shared 16-bit combinational ALU to execute compound operations the ALU has no single opcode for: subtract, negate, absolute value and 16x16 multiply (low 16 bits).
- Issues exactly one ALU opcode per cycle and captures the ALU output into internal registers.
- Sits beside the ALU in the execute stage, with a start/busy/done handshake toward the control unit.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that drives the shared 16-bit combinational ALU
// to build operations the ALU has no opcode for: SUB (a-b), NEG (-a), ABS (|a|)
// and MUL (low 16 bits of a*b). One ALU opcode is issued per cycle and the ALU
// output is captured at the edge that ends each state.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, cmd, a, b    request pulse (taken only when idle), command, operands
//   busy, done          busy from the cycle after an accepted start through DONE;
//                       done pulses for one cycle when result is valid
//   result              result register, held until the next done
//   res_n/res_z/res_p   condition codes of the result register
//   alu_in1/2, alu_op,  ALU drive (op 7 = zero when no ALU work is needed)
//   alu_shift
//   alu_out             combinational ALU result
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_n,
  output logic             res_z,
  output logic             res_p,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_shift,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpNot   = 3'd2;
  localparam logic [2:0] OpLshf  = 3'd4;
  localparam logic [2:0] OpRshfl = 3'd5;
  localparam logic [2:0] OpZero  = 3'd7;

  localparam logic [1:0] CmdSub = 2'b00;
  localparam logic [1:0] CmdNeg = 2'b01;
  localparam logic [1:0] CmdMul = 2'b10;
  localparam logic [1:0] CmdAbs = 2'b11;

  // The multiply bit-test has no state of its own: it is folded into the
  // transitions that lead into an iteration.
  typedef enum logic [3:0] {
    StIdle, StSNot, StSInc, StSAdd, StNNot, StNInc, StMAdd, StMLsh, StMRsh, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, tmp_q, tmp_d, acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ALU drive: purely a function of state and operand registers.
  always_comb begin
    alu_op    = OpZero;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_shift = '0;
    unique case (state_q)
      StSNot: begin alu_op = OpNot; alu_in1 = opb_q; end
      StSInc: begin alu_op = OpAdd; alu_in1 = tmp_q; alu_in2 = WIDTH'(1); end
      StSAdd: begin alu_op = OpAdd; alu_in1 = opa_q; alu_in2 = tmp_q; end
      StNNot: begin alu_op = OpNot; alu_in1 = opa_q; end
      StNInc: begin alu_op = OpAdd; alu_in1 = tmp_q; alu_in2 = WIDTH'(1); end
      StMAdd: begin alu_op = OpAdd; alu_in1 = acc_q; alu_in2 = mcand_q; end
      StMLsh: begin alu_op = OpLshf; alu_in1 = mcand_q; alu_shift = 4'd1; end
      StMRsh: begin alu_op = OpRshfl; alu_in1 = mplier_q; alu_shift = 4'd1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    tmp_d    = tmp_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d = a;
          opb_d = b;
          unique case (cmd)
            CmdSub: state_d = StSNot;
            CmdNeg: state_d = StNNot;
            CmdAbs: begin
              if (a[WIDTH-1]) begin
                state_d = StNNot;
              end else begin
                result_d = a;
                state_d  = StDone;
              end
            end
            CmdMul: begin
              if (a == '0 || b == '0) begin
                result_d = '0;
                state_d  = StDone;
              end else begin
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = '0;
                state_d  = b[0] ? StMAdd : StMLsh;
              end
            end
            default: ;
          endcase
        end
      end
      StSNot: begin tmp_d = alu_out; state_d = StSInc; end
      StSInc: begin tmp_d = alu_out; state_d = StSAdd; end
      StSAdd: begin result_d = alu_out; state_d = StDone; end
      StNNot: begin tmp_d = alu_out; state_d = StNInc; end
      StNInc: begin result_d = alu_out; state_d = StDone; end
      StMAdd: begin acc_d = alu_out; state_d = StMLsh; end
      StMLsh: begin mcand_d = alu_out; state_d = StMRsh; end
      StMRsh: begin
        mplier_d = alu_out;
        cnt_d    = cnt_q + CNT_W'(1);
        // Stop early once no multiplier bits remain.
        if (alu_out == '0 || cnt_d == CNT_W'(WIDTH)) begin
          result_d = acc_q;
          state_d  = StDone;
        end else begin
          state_d = alu_out[0] ? StMAdd : StMLsh;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      tmp_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      tmp_q    <= tmp_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign res_n  = result_q[WIDTH-1];
  assign res_z  = (result_q == '0);
  assign res_p  = ~result_q[WIDTH-1] & (result_q != '0);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  cmd;
  logic [15:0] a, b, result, alu_in1, alu_in2, alu_out;
  logic        busy, done, res_n, res_z, res_p;
  logic [2:0]  alu_op;
  logic [3:0]  alu_shift;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;
  int          cyc, nops;
  logic [47:0] seq;

  alu_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .res_n(res_n), .res_z(res_z), .res_p(res_p),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_shift(alu_shift),
    .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'd0: alu_out = alu_in1 + alu_in2;
      3'd1: alu_out = alu_in1 & alu_in2;
      3'd2: alu_out = ~alu_in1;
      3'd3: alu_out = alu_in1 ^ alu_in2;
      3'd4: alu_out = alu_in1 << alu_shift;
      3'd5: alu_out = alu_in1 >> alu_shift;
      3'd6: alu_out = $signed(alu_in1) >>> alu_shift;
      default: alu_out = '0;
    endcase
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command and returns at the done cycle (or after a bound).
  // cyc = cycle index of done counting the start edge as edge 0.
  // With hold set, start stays high and operands are scrambled while busy.
  task automatic run_op(input logic [1:0] c, input logic [15:0] xa, input logic [15:0] xb,
                        input bit hold);
    start = 1'b1; cmd = c; a = xa; b = xb;
    step();
    if (!hold) start = 1'b0;
    cyc = 1; nops = 0; seq = '0;
    while (!done && cyc < 200) begin
      if (alu_op != 3'd7) begin
        seq = {seq[44:0], alu_op};
        nops++;
      end
      if (hold) begin a = ~a; b = b + 16'h1111; cmd = cmd + 2'd1; end
      step();
      cyc++;
    end
    start = 1'b0;
    check("done_reached", {47'd0, done}, 48'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 2'b00; a = '0; b = '0;
    #2;
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_done", {47'd0, done}, 48'd0);
    check("rst_result", {32'd0, result}, 48'h0);
    check("rst_flags", {45'd0, res_n, res_z, res_p}, 48'b010);
    check("rst_alu_op", {45'd0, alu_op}, 48'd7);
    check("rst_alu_in", {alu_in1, alu_in2, 12'd0, alu_shift}, 48'd0);
    step();
    step();
    reset = 1'b0;

    // Reset in the middle of a multiply.
    start = 1'b1; cmd = 2'b10; a = 16'd3; b = 16'h00FF;
    step();
    start = 1'b0;
    repeat (3) step();
    check("mid_mul_busy", {47'd0, busy}, 48'd1);
    reset = 1'b1;
    #1;
    check("mrst_busy", {47'd0, busy}, 48'd0);
    check("mrst_result", {32'd0, result}, 48'h0);
    check("mrst_z", {47'd0, res_z}, 48'd1);
    check("mrst_alu_op", {45'd0, alu_op}, 48'd7);
    step();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) step();
    check("mrst_no_done", d0, done_cnt - 0 == d0 ? d0 : done_cnt);
    check("mrst_done_cnt", done_cnt, 48'd0);

    run_op(2'b00, 16'd1, 16'd1, 1'b0);
    check("sub11_cyc", cyc, 4);
    check("sub11_result", {32'd0, result}, 48'h0);
    check("sub11_z", {47'd0, res_z}, 48'd1);
    step();

    // SUB 5-7
    run_op(2'b00, 16'h0005, 16'h0007, 1'b0);
    check("sub_cyc", cyc, 4);
    check("sub_ops", {seq[8:0], 8'(nops)}, {9'o200, 8'd3});
    check("sub_result", {32'd0, result}, 48'hFFFE);
    check("sub_flags", {45'd0, res_n, res_z, res_p}, 48'b100);
    check("sub_busy_done", {47'd0, busy}, 48'd1);
    step();
    check("sub_after", {30'd0, busy, done, result}, {32'd0, 16'hFFFE});

    run_op(2'b01, 16'h0001, 16'h0000, 1'b0);
    check("neg_cyc", cyc, 3);
    check("neg_result", {32'd0, result}, 48'hFFFF);
    step();

    run_op(2'b11, 16'hFFF6, 16'h0000, 1'b0);
    check("abs_neg_cyc", cyc, 3);
    check("abs_neg_result", {32'd0, result}, 48'h000A);
    check("abs_neg_flags", {45'd0, res_n, res_z, res_p}, 48'b001);
    step();

    run_op(2'b11, 16'h0004, 16'h0000, 1'b0);
    check("abs_pos_cyc", cyc, 1);
    check("abs_pos_nops", nops, 0);
    check("abs_pos_result", {32'd0, result}, 48'h0004);
    step();

    run_op(2'b10, 16'd3, 16'd5, 1'b0);
    check("mul35_cyc", cyc, 9);
    check("mul35_ops", {seq[23:0], 8'(nops)}, {24'o04545045, 8'd8});
    check("mul35_result", {32'd0, result}, 48'h000F);
    step();

    run_op(2'b10, 16'h1234, 16'h0000, 1'b0);
    check("mul0_cyc", cyc, 1);
    check("mul0_result", {32'd0, result}, 48'h0);
    check("mul0_z", {47'd0, res_z}, 48'd1);
    step();

    run_op(2'b10, 16'hFFFF, 16'hFFFF, 1'b0);
    check("mulff_cyc", cyc, 49);
    check("mulff_nops", nops, 48);
    check("mulff_result", {32'd0, result}, 48'h0001);
    step();

    run_op(2'b10, 16'h0100, 16'h0100, 1'b0);
    check("mul_wrap_result", {32'd0, result}, 48'h0);
    step();

    run_op(2'b01, 16'h8000, 16'h0000, 1'b0);
    check("neg8000_result", {32'd0, result}, 48'h8000);
    check("neg8000_n", {47'd0, res_n}, 48'd1);
    step();
    run_op(2'b11, 16'h8000, 16'h0000, 1'b0);
    check("abs8000_result", {32'd0, result}, 48'h8000);
    step();

    // start held high while busy: ignored, single done, result held.
    d0 = done_cnt;
    run_op(2'b00, 16'd9, 16'd2, 1'b1);
    check("hold_cyc", cyc, 4);
    check("hold_result", {32'd0, result}, 48'h0007);
    repeat (3) step();
    check("hold_one_done", done_cnt, d0 + 1);
    check("hold_result_kept", {32'd0, result}, 48'h0007);
    check("hold_idle", {47'd0, busy}, 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
